// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// One full-subtractor cell is reused every cycle with a registered borrow
// carried between bit slices. Operands are captured on start and the result
// is presented with a one-cycle done pulse.

// Single-bit full subtractor cell: d = x - y - bi, borrow-out bo.
module serial_subtractor_fs (
  input  logic i_x,
  input  logic i_y,
  input  logic i_bi,
  output logic o_d,
  output logic o_bo
);
  assign o_d  = i_x ^ i_y ^ i_bi;
  assign o_bo = (~i_x & i_y) | (~(i_x ^ i_y) & i_bi);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a_sr, r_b_sr, r_res_sr;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_brw, r_bout, r_busy, r_done;
  logic             w_d, w_bo, w_load, w_last;

  // The cell always looks at the current LSBs; its output is only used in SHIFT.
  serial_subtractor_fs u_cell (
    .i_x  (r_a_sr[0]),
    .i_y  (r_b_sr[0]),
    .i_bi (r_brw),
    .o_d  (w_d),
    .o_bo (w_bo)
  );

  assign w_load = (r_state == S_IDLE) && start;
  assign w_last = (r_state == S_SHIFT) && (r_cnt == C_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: start only matters in IDLE; DONE lasts exactly one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == C_LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand shifters, running borrow and slice counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_brw    <= 1'b0;
      r_cnt    <= '0;
    end else if (w_load) begin
      r_a_sr <= a;
      r_b_sr <= b;
      r_brw  <= bin;
      r_cnt  <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
      // New bit enters at the MSB so the first bit lands in bit 0 after WIDTH shifts.
      r_res_sr <= {w_d, r_res_sr[WIDTH-1:1]};
      r_brw    <= w_bo;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  // Visible outputs: busy/done flags and a result that only moves at completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff <= '0;
      r_bout <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_busy <= 1'b1;
      end else if (w_last) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_diff <= {w_d, r_res_sr[WIDTH-1:1]};
        r_bout <= w_bo;
      end
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;
  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH 8, plus a shared
// random sweep across WIDTH 2, 8 and 16 instances.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // Directed instance (WIDTH=8).
  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0] diff8;
  logic       bout8, busy8, done8;

  // Sweep instances share stimulus; each takes the low bits of sa/sb.
  logic        ss = 1'b0, sbin = 1'b0;
  logic [15:0] sa = '0, sb = '0;
  logic [1:0]  d2;
  logic [7:0]  dm8;
  logic [15:0] d16;
  logic        bo2, bz2, dn2, bom8, bzm8, dnm8, bo16, bz16, dn16;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .diff(diff8), .bout(bout8), .busy(busy8), .done(done8));

  serial_subtractor #(.WIDTH(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .start(ss), .a(sa[1:0]), .b(sb[1:0]), .bin(sbin),
    .diff(d2), .bout(bo2), .busy(bz2), .done(dn2));

  serial_subtractor #(.WIDTH(8)) dut_w8 (
    .clk(clk), .rst_n(rst_n), .start(ss), .a(sa[7:0]), .b(sb[7:0]), .bin(sbin),
    .diff(dm8), .bout(bom8), .busy(bzm8), .done(dnm8));

  serial_subtractor #(.WIDTH(16)) dut_w16 (
    .clk(clk), .rst_n(rst_n), .start(ss), .a(sa), .b(sb), .bin(sbin),
    .diff(d16), .bout(bo16), .busy(bz16), .done(dn16));

  int total = 0;
  int bad = 0;
  int last_d = 0;
  int last_bo = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Apply operands with a one-cycle start pulse on the directed instance.
  task automatic launch(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
    @(negedge clk);
    a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Called at the first negedge after the accepting edge.
  task automatic wait_done(input string tag, input int ed, input int ebo);
    int  busy_cnt = 0;
    int  cyc = 0;
    bit  hold_ok = 1'b1;
    logic [7:0] ld;
    ld = last_d[7:0];
    while (done8 !== 1'b1 && cyc < 40) begin
      if (busy8 === 1'b1) busy_cnt++;
      if (diff8 !== ld || bout8 !== last_bo[0]) hold_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".done"}, done8, 1);
    chk({tag, ".diff"}, diff8, ed);
    chk({tag, ".bout"}, bout8, ebo);
    chk({tag, ".busycyc"}, busy_cnt, 8);
    chk({tag, ".hold"}, hold_ok, 1);
    last_d = ed; last_bo = ebo;
    @(negedge clk);
    chk({tag, ".pulse"}, done8, 0);
  endtask

  function automatic int exp_d(input int w, input logic [15:0] x, input logic [15:0] y, input logic bi);
    int m, t;
    m = (1 << w) - 1;
    t = int'(x & m) - int'(y & m) - int'(bi);
    return t & m;
  endfunction

  function automatic int exp_bo(input int w, input logic [15:0] x, input logic [15:0] y, input logic bi);
    int m, t;
    m = (1 << w) - 1;
    t = int'(x & m) - int'(y & m) - int'(bi);
    return (t < 0) ? 1 : 0;
  endfunction

  task automatic sweep_one();
    logic [15:0] ra, rb;
    logic        rbin;
    bit          g2 = 1'b0, g8 = 1'b0, g16 = 1'b0;
    int          cyc = 0;
    ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
    @(negedge clk);
    sa = ra; sb = rb; sbin = rbin; ss = 1'b1;
    @(negedge clk);
    ss = 1'b0;
    while (!(g2 && g8 && g16) && cyc < 40) begin
      if (!g2 && dn2 === 1'b1) begin
        g2 = 1'b1;
        chk("sw2.diff", d2, exp_d(2, ra, rb, rbin));
        chk("sw2.bout", bo2, exp_bo(2, ra, rb, rbin));
      end
      if (!g8 && dnm8 === 1'b1) begin
        g8 = 1'b1;
        chk("sw8.diff", dm8, exp_d(8, ra, rb, rbin));
        chk("sw8.bout", bom8, exp_bo(8, ra, rb, rbin));
      end
      if (!g16 && dn16 === 1'b1) begin
        g16 = 1'b1;
        chk("sw16.diff", d16, exp_d(16, ra, rb, rbin));
        chk("sw16.bout", bo16, exp_bo(16, ra, rb, rbin));
      end
      @(negedge clk);
      cyc++;
    end
    chk("sw.alldone", {29'd0, g2, g8, g16}, 7);
    @(negedge clk);
  endtask

  initial begin
    bit seen;
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst.diff", diff8, 0);
    chk("rst.bout", bout8, 0);
    chk("rst.busy", busy8, 0);
    chk("rst.done", done8, 0);
    rst_n = 1'b1;

    // Directed vectors.
    launch(8'd100, 8'd37, 1'b0);  wait_done("v100_37", 63, 0);
    launch(8'd5, 8'd10, 1'b0);    wait_done("v5_10", 251, 1);
    launch(8'd0, 8'd0, 1'b1);     wait_done("v0_0_1", 255, 1);
    launch(8'd255, 8'd255, 1'b1); wait_done("v255_255_1", 255, 1);
    launch(8'd200, 8'd199, 1'b1); wait_done("v200_199_1", 0, 0);

    // Start held high and operands changed during SHIFT.
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd3; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'd0; b8 = 8'd0;
    wait_done("held", 6, 0);
    start8 = 1'b0;
    chk("held.idle0", busy8, 0);
    @(negedge clk);
    chk("held.idle1", busy8, 0);

    // Asynchronous reset mid-operation.
    launch(8'd100, 8'd37, 1'b0);
    repeat (4) @(negedge clk);
    chk("abort.busy_pre", busy8, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort.diff", diff8, 0);
    chk("abort.bout", bout8, 0);
    chk("abort.busy", busy8, 0);
    chk("abort.done", done8, 0);
    last_d = 0; last_bo = 0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8 !== 1'b0) seen = 1'b1;
    end
    chk("abort.nodone", seen, 0);
    launch(8'd7, 8'd2, 1'b0); wait_done("v7_2", 5, 0);

    // Back-to-back: next request presented while the first is still running,
    // held through the done cycle until accepted from IDLE.
    launch(8'd50, 8'd20, 1'b0);
    a8 = 8'd1; b8 = 8'd2; bin8 = 1'b0; start8 = 1'b1;
    wait_done("b2b.first", 30, 0);
    @(negedge clk);
    start8 = 1'b0;
    wait_done("b2b.second", 255, 1);

    // Random sweep across widths.
    for (int i = 0; i < 1000; i++) sweep_one();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
